// File: rtl/attn_seq_ctrl.sv
// Attention score sequencer: loads one query vector, streams key vectors through an external MAC,
// and forwards e^x scores to a credit-flow-controlled master port through a 2-entry FIFO.
module attn_seq_ctrl #(
  parameter int unsigned FEAT    = 4,
  parameter int unsigned NKEYS   = 4,
  parameter int unsigned CREDITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_vld,
  output logic       s_rdy,
  output logic [7:0] dp_a,
  output logic [7:0] dp_b,
  output logic       dp_en,
  output logic       dp_clr,
  input  logic [8:0] dp_ex,
  output logic [7:0] m_data,
  output logic       m_vld,
  output logic       m_last,
  input  logic       m_credit
);

  localparam int unsigned FW = (FEAT > 1) ? $clog2(FEAT) : 1;
  localparam int unsigned KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam logic [FW-1:0] FeatLast = FW'(FEAT - 1);
  localparam logic [KW-1:0] KeyLast  = KW'(NKEYS - 1);
  localparam logic [1:0]    CcMax    = 2'(CREDITS);

  localparam logic [1:0] LOADQ = 2'd0;
  localparam logic [1:0] KEY   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] qi_q, qi_d;
  logic [FW-1:0] fi_q, fi_d;
  logic [KW-1:0] ki_q, ki_d;
  logic [7:0]    q_mem_q [FEAT];
  logic [7:0]    q_mem_d [FEAT];

  // Score FIFO entries are {last, score}.
  logic [8:0] fifo_q [2];
  logic [8:0] fifo_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] cc_q, cc_d;

  logic       hs, key_hs, push, pop, fifo_full, fifo_empty;
  logic [8:0] head;

  // Outputs are forced quiet while reset is asserted, not just after the first clock.
  assign s_rdy      = rst_n & ((state_q == LOADQ) | (state_q == KEY));
  assign hs         = s_vld & s_rdy;
  assign key_hs     = hs & (state_q == KEY);
  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);
  assign push       = (state_q == DRAIN) & ~fifo_full;
  assign m_vld      = rst_n & ~fifo_empty & (cc_q != 2'd0);
  assign pop        = m_vld;
  assign head       = fifo_q[rd_ptr_q];

  assign dp_en  = key_hs;
  assign dp_clr = key_hs & (fi_q == '0);
  assign dp_a   = key_hs ? q_mem_q[fi_q] : 8'h00;
  assign dp_b   = key_hs ? s_data : 8'h00;

  assign m_data = m_vld ? head[7:0] : 8'h00;
  assign m_last = m_vld & head[8];

  always_comb begin
    state_d = state_q;
    qi_d    = qi_q;
    fi_d    = fi_q;
    ki_d    = ki_q;
    q_mem_d = q_mem_q;
    unique case (state_q)
      LOADQ: begin
        if (hs) begin
          q_mem_d[qi_q] = s_data;
          if (qi_q == FeatLast) begin
            qi_d    = '0;
            ki_d    = '0;
            fi_d    = '0;
            state_d = KEY;
          end else begin
            qi_d = qi_q + 1'b1;
          end
        end
      end
      KEY: begin
        if (hs) begin
          if (fi_q == FeatLast) begin
            fi_d    = '0;
            state_d = DRAIN;
          end else begin
            fi_d = fi_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Stay here while the FIFO is full; the datapath keeps dp_ex stable meanwhile.
        if (push) begin
          if (ki_q == KeyLast) begin
            qi_d    = '0;
            state_d = LOADQ;
          end else begin
            ki_d    = ki_q + 1'b1;
            state_d = KEY;
          end
        end
      end
      default: state_d = LOADQ;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (push) begin
      fifo_d[wr_ptr_q] = {(ki_q == KeyLast), dp_ex[7:0]};
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    cc_d = cc_q;
    if (pop && !m_credit) begin
      cc_d = cc_q - 2'd1;
    end else if (m_credit && !pop && (cc_q < CcMax)) begin
      cc_d = cc_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOADQ;
      qi_q     <= '0;
      fi_q     <= '0;
      ki_q     <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      cc_q     <= CcMax;
      for (int i = 0; i < FEAT; i++) begin
        q_mem_q[i] <= 8'h00;
      end
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= 9'h000;
      end
    end else begin
      state_q  <= state_d;
      qi_q     <= qi_d;
      fi_q     <= fi_d;
      ki_q     <= ki_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cc_q     <= cc_d;
      q_mem_q  <= q_mem_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Directed bench for attn_seq_ctrl with a behavioural MAC/e^x model and a score scoreboard.
module tb_attn_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_vld;
  logic       s_rdy;
  logic [7:0] dp_a, dp_b;
  logic       dp_en, dp_clr;
  logic [8:0] dp_ex;
  logic [7:0] m_data;
  logic       m_vld, m_last;
  logic       m_credit;

  logic       auto_credit, credit_auto, credit_man;
  int         checks, passes, beats;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] q_model [4];
  logic [31:0] q_cur;
  logic [15:0] acc_m;
  logic signed [15:0] prod_m;

  attn_seq_ctrl #(.FEAT(4), .NKEYS(4), .CREDITS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_vld    (s_vld),
    .s_rdy    (s_rdy),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_en    (dp_en),
    .dp_clr   (dp_clr),
    .dp_ex    (dp_ex),
    .m_data   (m_data),
    .m_vld    (m_vld),
    .m_last   (m_last),
    .m_credit (m_credit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Opaque e^x stand-in: any fixed mixing of the accumulator will do.
  function automatic logic [8:0] ex_f(input logic [15:0] a);
    return a[15:7] ^ a[8:0];
  endfunction

  function automatic logic [8:0] exp_score(input logic [31:0] qv, input logic [31:0] kv,
                                           input logic last);
    logic [15:0] acc;
    logic signed [15:0] p;
    logic [8:0] ex;
    acc = 16'h0000;
    for (int f = 0; f < 4; f++) begin
      p   = $signed(qv[8*f +: 8]) * $signed(kv[8*f +: 8]);
      acc = acc + p;
    end
    ex = ex_f(acc);
    return {last, ex[7:0]};
  endfunction

  assign prod_m = $signed(dp_a) * $signed(dp_b);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_m <= 16'h0000;
    else if (dp_en) acc_m <= dp_clr ? prod_m : acc_m + prod_m;
  end
  assign dp_ex = ex_f(acc_m);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_auto <= 1'b0;
    else credit_auto <= auto_credit & m_vld;
  end
  assign m_credit = credit_auto | credit_man;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && m_vld) begin
      beats++;
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'(m_vld), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("score_data", 32'(m_data), 32'(mon_e[7:0]));
        chk("score_last", 32'(m_last), 32'(mon_e[8]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit is_k, input int f);
    int n;
    s_data = d;
    s_vld  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("hs_timeout", 32'd0, 32'd1);
    if (is_k) begin
      chk("k_dp_en", 32'(dp_en), 32'd1);
      chk("k_dp_clr", 32'(dp_clr), 32'(f == 0));
      chk("k_dp_a", 32'(dp_a), 32'(q_model[f]));
      chk("k_dp_b", 32'(dp_b), 32'(d));
    end else begin
      chk("q_dp_en", 32'(dp_en), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_q(input logic [31:0] qv);
    q_cur = qv;
    for (int f = 0; f < 4; f++) begin
      q_model[f] = qv[8*f +: 8];
      send_byte(qv[8*f +: 8], 1'b0, f);
    end
  endtask

  task automatic send_k(input logic [31:0] kv, input bit last, input bit gap, input bit lat);
    for (int f = 0; f < 4; f++) begin
      send_byte(kv[8*f +: 8], 1'b1, f);
      if (gap && f < 3) begin
        s_vld = 1'b0;
        @(negedge clk);
        chk("gap_dp_en", 32'(dp_en), 32'd0);
        chk("gap_dp_clr", 32'(dp_clr), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    exp_q.push_back(exp_score(q_cur, kv, last));
    if (lat) s_vld = 1'b0;
    @(negedge clk);
    chk("drain_s_rdy", 32'(s_rdy), 32'd0);
    if (lat) chk("lat_m_vld_t1", 32'(m_vld), 32'd0);
    @(posedge clk);
    #1;
    if (lat) begin
      @(negedge clk);
      chk("lat_m_vld_t2", 32'(m_vld), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    s_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int b0;

  initial begin
    checks = 0; passes = 0; beats = 0;
    rst_n = 1'b0; s_vld = 1'b0; s_data = 8'h00;
    credit_man = 1'b0; auto_credit = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_rdy", 32'(s_rdy), 32'd0);
    chk("rst_m_vld", 32'(m_vld), 32'd0);
    chk("rst_dp_en", 32'(dp_en), 32'd0);
    chk("rst_outs", {dp_a, dp_b, m_data, 6'd0, dp_clr, m_last}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Query 1: 0.5 x 0.5 dot products with latency probe on key 0, s_vld held high.
    send_q(32'h40404040);
    send_k(32'h40404040, 1'b0, 1'b0, 1'b1);
    send_k(32'h7F80017F, 1'b0, 1'b0, 1'b0);
    send_k(32'h11223344, 1'b0, 1'b0, 1'b0);
    send_k(32'hF0E0D0C0, 1'b1, 1'b0, 1'b0);
    idle(1);
    wait_drain();
    chk("q1_beats", 32'(beats), 32'd4);

    // Same query without and with s_vld bubbles must score identically.
    for (int r = 0; r < 2; r++) begin
      send_q(32'h8107C37A);
      send_k(32'h5A3C96E1, 1'b0, r[0], 1'b0);
      send_k(32'h0F1E2D3C, 1'b0, r[0], 1'b0);
      send_k(32'h80808080, 1'b0, r[0], 1'b0);
      send_k(32'h7F7F7F7F, 1'b1, r[0], 1'b0);
    end
    idle(1);
    wait_drain();
    chk("q23_beats", 32'(beats), 32'd12);

    // Excess credits at the maximum must be ignored.
    auto_credit = 1'b0;
    credit_man  = 1'b1;
    repeat (3) @(posedge clk);
    #1 credit_man = 1'b0;
    b0 = beats;

    send_q(32'h12345678);
    send_k(32'hA1B2C3D4, 1'b0, 1'b0, 1'b0);
    send_k(32'h0102F3F4, 1'b0, 1'b0, 1'b0);
    send_k(32'h7F018002, 1'b0, 1'b0, 1'b0);
    send_k(32'hC0C04040, 1'b1, 1'b0, 1'b0);
    send_q(32'h9ABCDEF0);
    send_k(32'h01020304, 1'b0, 1'b0, 1'b0);
    s_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_s_rdy", 32'(s_rdy), 32'd0);
      chk("stall_m_vld", 32'(m_vld), 32'd0);
      chk("stall_m_quiet", {m_data, m_last}, 32'd0);
    end
    chk("stall_beats", 32'(beats - b0), 32'd2);

    // One credit, then a second one coinciding with the resulting beat.
    @(posedge clk);
    #1 credit_man = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("credit_beat1", 32'(m_vld), 32'd1);
    @(posedge clk);
    #1 credit_man = 1'b0;
    @(negedge clk);
    chk("credit_beat2", 32'(m_vld), 32'd1);
    chk("drain_push_s_rdy", 32'(s_rdy), 32'd0);
    @(negedge clk);
    chk("credit_spent", 32'(m_vld), 32'd0);
    chk("drain_exit_s_rdy", 32'(s_rdy), 32'd1);
    repeat (3) @(negedge clk);
    chk("coincident_beats", 32'(beats - b0), 32'd4);
    @(posedge clk);
    #1;

    // Reset in the middle of key 1 discards the partial vector and the queued score.
    send_byte(8'h05, 1'b1, 0);
    send_byte(8'h06, 1'b1, 1);
    rst_n  = 1'b0;
    s_vld  = 1'b1;
    s_data = 8'hAA;
    @(negedge clk);
    chk("mid_rst_s_rdy", 32'(s_rdy), 32'd0);
    chk("mid_rst_m_vld", 32'(m_vld), 32'd0);
    chk("mid_rst_dp", {dp_a, dp_b, m_data, 5'd0, dp_en, dp_clr, m_last}, 32'd0);
    s_vld = 1'b0;
    exp_q.delete();
    auto_credit = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    b0 = beats;
    repeat (4) @(negedge clk);
    chk("post_rst_no_beat", 32'(beats - b0), 32'd0);
    @(posedge clk);
    #1;
    send_q(32'h40404040);
    send_k(32'h40404040, 1'b0, 1'b0, 1'b1);
    idle(1);
    wait_drain();
    chk("post_rst_beats", 32'(beats - b0), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
